// File: rtl/mon_pkg.sv
// mon_pkg: shared state encoding, default widths and saturating increment for the mismatch monitor.
package mon_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        REPORT = 2'd2
    } state_e;

    localparam int DEF_WIDTH = 1;
    localparam int DEF_CNT_W = 16;
    localparam int DEF_TS_W  = 16;

    // Counters up to 32 bits wide; the value sticks at 2^w-1.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
        logic [31:0] max;
        max = (w >= 32) ? '1 : (32'd1 << w) - 32'd1;
        return (v >= max) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter with synchronous clear that sticks at its all-ones value.
module sat_counter
    import mon_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    always_comb count_d = clr ? '0 : inc ? W'(sat_inc(32'(count_q), W)) : count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/vector_mismatch_monitor.sv
// vector_mismatch_monitor: counts ref/dut sample beats and mismatches per run and hands off a pass/fail report.
// MISMATCH_CAPTURE_EN adds first_err_ref/first_err_dut capture and a sticky err_mask of differing bits.
module vector_mismatch_monitor
    import mon_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W,
    parameter int TS_W  = DEF_TS_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] ref_vec,
    input  logic [WIDTH-1:0] dut_vec,
    output logic             busy,
    output logic [CNT_W-1:0] samples,
    output logic [CNT_W-1:0] errors,
    output logic [TS_W-1:0]  first_err_cycle,
    output logic             first_err_valid,
`ifdef MISMATCH_CAPTURE_EN
    output logic [WIDTH-1:0] first_err_ref,
    output logic [WIDTH-1:0] first_err_dut,
    output logic [WIDTH-1:0] err_mask,
`endif
    output logic             report_valid,
    input  logic             report_ready,
    output logic             pass
);

    state_e          state_q, state_d;
    logic            clr_run, beat, miss, capture;
    logic [TS_W-1:0] cycle;
    logic [TS_W-1:0] fec_q, fec_d;
    logic            fev_q, fev_d;

    assign clr_run = (state_q == IDLE) && start;
    assign beat    = (state_q == RUN) && sample_valid;
    assign miss    = beat && (ref_vec != dut_vec);
    assign capture = miss && !fev_q;

    always_comb begin
        state_d      = state_q;
        busy         = state_q == RUN;
        report_valid = state_q == REPORT;
        pass         = (state_q == REPORT) && (errors == '0);
        case (state_q)
            IDLE:    state_d = start ? RUN : IDLE;
            RUN:     state_d = stop ? REPORT : RUN;
            REPORT:  state_d = report_ready ? IDLE : REPORT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    sat_counter #(.W(CNT_W)) u_samples (
        .clk(clk), .rst(reset), .clr(clr_run), .inc(beat), .count(samples)
    );

    sat_counter #(.W(CNT_W)) u_errors (
        .clk(clk), .rst(reset), .clr(clr_run), .inc(miss), .count(errors)
    );

    // Run-cycle index: zero on the first RUN cycle, frozen outside RUN.
    sat_counter #(.W(TS_W)) u_cycle (
        .clk(clk), .rst(reset), .clr(clr_run), .inc(state_q == RUN), .count(cycle)
    );

    always_comb begin
        fev_d = clr_run ? 1'b0 : (fev_q | capture);
        fec_d = clr_run ? '0 : capture ? cycle : fec_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fev_q <= 1'b0;
            fec_q <= '0;
        end else begin
            fev_q <= fev_d;
            fec_q <= fec_d;
        end
    end

    assign first_err_valid = fev_q;
    assign first_err_cycle = fec_q;

`ifdef MISMATCH_CAPTURE_EN
    logic [WIDTH-1:0] fref_q, fref_d, fdut_q, fdut_d, mask_q, mask_d;

    always_comb begin
        fref_d = clr_run ? '0 : capture ? ref_vec : fref_q;
        fdut_d = clr_run ? '0 : capture ? dut_vec : fdut_q;
        mask_d = clr_run ? '0 : beat ? (mask_q | (ref_vec ^ dut_vec)) : mask_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fref_q <= '0;
            fdut_q <= '0;
            mask_q <= '0;
        end else begin
            fref_q <= fref_d;
            fdut_q <= fdut_d;
            mask_q <= mask_d;
        end
    end

    assign first_err_ref = fref_q;
    assign first_err_dut = fdut_q;
    assign err_mask      = mask_q;
`endif

endmodule

// File: tb/tb_vector_mismatch_monitor.sv
// tb_vector_mismatch_monitor: directed runs on a 16-bit-counter and a 4-bit-counter monitor checked against a behavioural model.
module tb_vector_mismatch_monitor;

    logic clk = 1'b0, reset = 1'b0, start = 1'b0, stop = 1'b0;
    logic sample_valid = 1'b0, report_ready = 1'b0;
    logic ref_vec = 1'b0, dut_vec = 1'b0;

    logic        a_busy, a_fev, a_rv, a_pass, b_busy, b_fev, b_rv, b_pass;
    logic [15:0] a_samples, a_errors, a_fec, b_fec;
    logic [3:0]  b_samples, b_errors;
`ifdef MISMATCH_CAPTURE_EN
    logic a_fref, a_fdut, a_mask, b_fref, b_fdut, b_mask;
`endif

    int n_vec = 0, n_miss = 0;

    int   mode = 0, ns = 0, ne = 0, rc = 0, fec = 0;
    logic fev = 1'b0, fref = 1'b0, fdut = 1'b0, mask = 1'b0;

    always #5 clk = ~clk;

    vector_mismatch_monitor #(.WIDTH(1), .CNT_W(16), .TS_W(16)) u_a (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .sample_valid(sample_valid), .ref_vec(ref_vec), .dut_vec(dut_vec),
        .busy(a_busy), .samples(a_samples), .errors(a_errors),
        .first_err_cycle(a_fec), .first_err_valid(a_fev),
`ifdef MISMATCH_CAPTURE_EN
        .first_err_ref(a_fref), .first_err_dut(a_fdut), .err_mask(a_mask),
`endif
        .report_valid(a_rv), .report_ready(report_ready), .pass(a_pass)
    );

    vector_mismatch_monitor #(.WIDTH(1), .CNT_W(4), .TS_W(16)) u_b (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .sample_valid(sample_valid), .ref_vec(ref_vec), .dut_vec(dut_vec),
        .busy(b_busy), .samples(b_samples), .errors(b_errors),
        .first_err_cycle(b_fec), .first_err_valid(b_fev),
`ifdef MISMATCH_CAPTURE_EN
        .first_err_ref(b_fref), .first_err_dut(b_fdut), .err_mask(b_mask),
`endif
        .report_valid(b_rv), .report_ready(report_ready), .pass(b_pass)
    );

    function automatic int sat(int v, int w);
        return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
    endfunction

    function automatic logic pat(int i);
        logic [3:0] n;
        n = 4'(i);
        return (n[3] | n[2]) & (n[1] | n[0]);
    endfunction

    task automatic chk(string nm, int act, int exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: mode 0 idle, 1 running, 2 reporting; counts kept unbounded and saturated on compare.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mode <= 0; ns <= 0; ne <= 0; rc <= 0; fec <= 0;
            fev <= 1'b0; fref <= 1'b0; fdut <= 1'b0; mask <= 1'b0;
        end else if (mode == 0) begin
            if (start) begin
                mode <= 1; ns <= 0; ne <= 0; rc <= 0; fec <= 0;
                fev <= 1'b0; fref <= 1'b0; fdut <= 1'b0; mask <= 1'b0;
            end
        end else if (mode == 1) begin
            rc <= rc + 1;
            if (stop) mode <= 2;
            if (sample_valid) begin
                ns   <= ns + 1;
                mask <= mask | (ref_vec ^ dut_vec);
                if (ref_vec != dut_vec) begin
                    ne <= ne + 1;
                    if (!fev) begin
                        fev <= 1'b1; fec <= rc; fref <= ref_vec; fdut <= dut_vec;
                    end
                end
            end
        end else if (report_ready) begin
            mode <= 0;
        end
    end

    always @(negedge clk) begin
        chk("a_busy", int'(a_busy), int'(mode == 1));
        chk("a_report_valid", int'(a_rv), int'(mode == 2));
        chk("a_pass", int'(a_pass), int'(mode == 2 && ne == 0));
        chk("a_samples", int'(a_samples), sat(ns, 16));
        chk("a_errors", int'(a_errors), sat(ne, 16));
        chk("a_first_err_cycle", int'(a_fec), fec);
        chk("a_first_err_valid", int'(a_fev), int'(fev));
        chk("b_busy", int'(b_busy), int'(mode == 1));
        chk("b_report_valid", int'(b_rv), int'(mode == 2));
        chk("b_pass", int'(b_pass), int'(mode == 2 && ne == 0));
        chk("b_samples", int'(b_samples), sat(ns, 4));
        chk("b_errors", int'(b_errors), sat(ne, 4));
        chk("b_first_err_cycle", int'(b_fec), fec);
        chk("b_first_err_valid", int'(b_fev), int'(fev));
`ifdef MISMATCH_CAPTURE_EN
        chk("a_first_err_ref", int'(a_fref), int'(fref));
        chk("a_first_err_dut", int'(a_fdut), int'(fdut));
        chk("a_err_mask", int'(a_mask), int'(mask));
        chk("b_err_mask", int'(b_mask), int'(mask));
`endif
    end

    task automatic cyc(logic st, logic sp, logic sv, logic r, logic d, logic rdy);
        start = st; stop = sp; sample_valid = sv; ref_vec = r; dut_vec = d; report_ready = rdy;
        @(negedge clk);
    endtask

    initial begin
        #1 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", int'(a_busy), 0);
        chk("rst_report_valid", int'(a_rv), 0);
        chk("rst_samples", int'(a_samples), 0);
        chk("rst_pass", int'(a_pass), 0);

        // Clean run of 16 beats.
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) cyc(0, 0, 1, pat(i), pat(i), 0);
        cyc(0, 1, 0, 0, 0, 0);
        chk("s1_report_valid", int'(a_rv), 1);
        chk("s1_samples", int'(a_samples), 16);
        chk("s1_errors", int'(a_errors), 0);
        chk("s1_pass", int'(a_pass), 1);
        chk("s1_first_err_valid", int'(a_fev), 0);
        chk("s1_b_samples", int'(b_samples), 15);
        cyc(0, 0, 0, 0, 0, 1);

        // Same run with dut inverted at run-cycles 3 and 7.
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) cyc(0, 0, 1, pat(i), (i == 3 || i == 7) ? ~pat(i) : pat(i), 0);
        cyc(0, 1, 0, 0, 0, 0);
        chk("s2_errors", int'(a_errors), 2);
        chk("s2_first_err_cycle", int'(a_fec), 3);
        chk("s2_first_err_valid", int'(a_fev), 1);
        chk("s2_pass", int'(a_pass), 0);
`ifdef MISMATCH_CAPTURE_EN
        chk("s2_first_err_ref", int'(a_fref), 0);
        chk("s2_first_err_dut", int'(a_fdut), 1);
        chk("s2_err_mask", int'(a_mask), 1);
`endif
        cyc(0, 0, 0, 0, 0, 1);

        // Idle beats and stray ready are ignored; start with stop in IDLE starts a run.
        cyc(0, 0, 1, 0, 1, 1);
        chk("s3_idle_samples", int'(a_samples), 16);
        chk("s3_idle_errors", int'(a_errors), 2);
        cyc(1, 1, 0, 0, 0, 0);
        chk("s3_busy", int'(a_busy), 1);
        chk("s3_cleared_samples", int'(a_samples), 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 1, 1, 0);
        cyc(0, 1, 1, 0, 0, 0);
        chk("s3_samples", int'(a_samples), 5);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 1, 0, 0, 0, 0);
            chk("s3_hold_report_valid", int'(a_rv), 1);
            chk("s3_hold_busy", int'(a_busy), 0);
        end
        cyc(0, 0, 0, 0, 0, 1);
        chk("s3_idle_report_valid", int'(a_rv), 0);
        chk("s3_retained_samples", int'(a_samples), 5);

        // 20 mismatching beats, with a start mid-run that must be ignored.
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) cyc(i == 10, 0, 1, 1, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        chk("s4_a_samples", int'(a_samples), 20);
        chk("s4_a_errors", int'(a_errors), 20);
        chk("s4_b_samples", int'(b_samples), 15);
        chk("s4_b_errors", int'(b_errors), 15);
        chk("s4_first_err_cycle", int'(a_fec), 0);
        cyc(0, 0, 0, 0, 0, 1);

        // Asynchronous reset after three beats aborts the run at once.
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 1, 0);
        sample_valid = 1'b1;
        #2 reset = 1'b1;
        #1;
        chk("s5_busy", int'(a_busy), 0);
        chk("s5_samples", int'(a_samples), 0);
        chk("s5_errors", int'(a_errors), 0);
        chk("s5_first_err_valid", int'(a_fev), 0);
        chk("s5_first_err_cycle", int'(a_fec), 0);
        @(negedge clk);
        reset = 1'b0;
        cyc(0, 0, 1, 0, 1, 0);
        cyc(0, 1, 0, 0, 0, 1);
        chk("s5_idle_report_valid", int'(a_rv), 0);
        chk("s5_idle_busy", int'(a_busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
